// File: rtl/wb_epbuf_dma.sv
// Block-copy DMA between the USB endpoint buffer and a Wishbone slave.
// One word in flight at a time; direction is selected per command.
module wb_epbuf_dma #(
  parameter int AW  = 9,
  parameter int WAW = 16,
  parameter int DW  = 32,
  parameter int LW  = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_dir,
  input  logic [AW-1:0]  cmd_ep_addr,
  input  logic [WAW-1:0] cmd_wb_addr,
  input  logic [LW-1:0]  cmd_len,
  output logic           busy,
  output logic           done,
  output logic [WAW-1:0] wb_addr,
  input  logic [DW-1:0]  wb_rdata,
  output logic [DW-1:0]  wb_wdata,
  output logic           wb_we,
  output logic           wb_cyc,
  input  logic           wb_ack,
  output logic [AW-1:0]  ep_tx_addr_0,
  output logic [DW-1:0]  ep_tx_data_0,
  output logic           ep_tx_we_0,
  output logic [AW-1:0]  ep_rx_addr_0,
  input  logic [DW-1:0]  ep_rx_data_1,
  output logic           ep_rx_re_0
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EP_RD,
    S_EP_LAT,
    S_WB_WR,
    S_WB_RD,
    S_EP_WR,
    S_FIN
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic           dir_q;
  logic [AW-1:0]  ep_q;
  logic [WAW-1:0] wa_q;
  logic [LW-1:0]  cnt_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  tdata_q;
  logic           accept;
  logic           last;
  logic           step;

  assign accept = cmd_valid && (state == S_IDLE);
  assign last   = (cnt_q == LW'(1));
  // a word is finished on the write side of either direction
  assign step   = ((state == S_WB_WR) && wb_ack) ||
                  (state == S_EP_WR);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) state_nx = S_FIN;
          else if (cmd_dir)  state_nx = S_WB_RD;
          else               state_nx = S_EP_RD;
        end
      end
      S_EP_RD:  state_nx = S_EP_LAT;
      S_EP_LAT: state_nx = S_WB_WR;
      S_WB_WR: begin
        if (wb_ack) begin
          if (last) state_nx = S_FIN;
          else      state_nx = dir_q ? S_WB_RD : S_EP_RD;
        end
      end
      S_WB_RD: begin
        if (wb_ack) state_nx = S_EP_WR;
      end
      S_EP_WR: begin
        if (last) state_nx = S_FIN;
        else      state_nx = dir_q ? S_WB_RD : S_EP_RD;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    wb_cyc     = 1'b0;
    wb_we      = 1'b0;
    ep_rx_re_0 = 1'b0;
    ep_tx_we_0 = 1'b0;
    unique case (state)
      S_IDLE:   cmd_ready = 1'b1;
      S_EP_RD: begin
        busy       = 1'b1;
        ep_rx_re_0 = 1'b1;
      end
      S_EP_LAT: busy = 1'b1;
      S_WB_WR: begin
        busy   = 1'b1;
        wb_cyc = 1'b1;
        wb_we  = 1'b1;
      end
      S_WB_RD: begin
        busy   = 1'b1;
        wb_cyc = 1'b1;
      end
      S_EP_WR: begin
        busy       = 1'b1;
        ep_tx_we_0 = 1'b1;
      end
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= 1'b0;
      ep_q    <= '0;
      wa_q    <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      tdata_q <= '0;
    end else begin
      if (accept) begin
        dir_q <= cmd_dir;
        ep_q  <= cmd_ep_addr;
        wa_q  <= cmd_wb_addr;
        cnt_q <= cmd_len;
      end else if (step) begin
        ep_q  <= ep_q + AW'(1);
        wa_q  <= wa_q + WAW'(1);
        cnt_q <= cnt_q - LW'(1);
      end
      if (state == S_EP_LAT)
        wdata_q <= ep_rx_data_1;
      if ((state == S_WB_RD) && wb_ack)
        tdata_q <= wb_rdata;
    end
  end

  assign wb_addr      = wa_q;
  assign wb_wdata     = wdata_q;
  assign ep_tx_addr_0 = ep_q;
  assign ep_rx_addr_0 = ep_q;
  assign ep_tx_data_0 = tdata_q;

endmodule

// File: tb/tb_wb_epbuf_dma.sv
// Bench for wb_epbuf_dma: table vectors, random commands against a
// word-copy model, plus busy-ignore and mid-transfer reset sequences.
module tb_wb_epbuf_dma;
  localparam int AW  = 9;
  localparam int WAW = 16;
  localparam int DW  = 32;
  localparam int LW  = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_dir;
  logic [AW-1:0]  cmd_ep_addr;
  logic [WAW-1:0] cmd_wb_addr;
  logic [LW-1:0]  cmd_len;
  logic           busy;
  logic           done;
  logic [WAW-1:0] wb_addr;
  logic [DW-1:0]  wb_rdata;
  logic [DW-1:0]  wb_wdata;
  logic           wb_we;
  logic           wb_cyc;
  logic           wb_ack;
  logic [AW-1:0]  ep_tx_addr_0;
  logic [DW-1:0]  ep_tx_data_0;
  logic           ep_tx_we_0;
  logic [AW-1:0]  ep_rx_addr_0;
  logic [DW-1:0]  ep_rx_data_1;
  logic           ep_rx_re_0;

  wb_epbuf_dma #(.AW(AW), .WAW(WAW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_ep_addr(cmd_ep_addr),
    .cmd_wb_addr(cmd_wb_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .wb_addr(wb_addr), .wb_rdata(wb_rdata),
    .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .ep_tx_addr_0(ep_tx_addr_0), .ep_tx_data_0(ep_tx_data_0),
    .ep_tx_we_0(ep_tx_we_0), .ep_rx_addr_0(ep_rx_addr_0),
    .ep_rx_data_1(ep_rx_data_1), .ep_rx_re_0(ep_rx_re_0)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ep_mem [0:(1<<AW)-1];
  logic [DW-1:0] wb_mem [0:(1<<WAW)-1];
  logic [DW-1:0] exp_ep [0:(1<<AW)-1];
  logic [DW-1:0] exp_wb [0:(1<<WAW)-1];

  int checks = 0;
  int errors = 0;
  int ws = 0;
  int wc = 0;
  int n_wwr = 0;
  int n_wrd = 0;
  int n_epwe = 0;
  int n_epre = 0;
  int viol = 0;

  // Wishbone slave with ws wait states and a registered ack
  always @(posedge clk) begin
    if (rst) begin
      wb_ack <= 1'b0;
      wc = 0;
    end else if (wb_cyc && !wb_ack) begin
      if (wc >= ws) begin
        wb_ack <= 1'b1;
        wc = 0;
        if (wb_we) begin
          wb_mem[wb_addr] = wb_wdata;
          n_wwr++;
        end else begin
          wb_rdata <= wb_mem[wb_addr];
          n_wrd++;
        end
      end else begin
        wc++;
      end
    end else begin
      wb_ack <= 1'b0;
    end
  end

  // Endpoint buffer: one-cycle read latency
  always @(posedge clk) begin
    if (ep_rx_re_0) begin
      ep_rx_data_1 <= ep_mem[ep_rx_addr_0];
      n_epre++;
    end
    if (ep_tx_we_0) begin
      ep_mem[ep_tx_addr_0] = ep_tx_data_0;
      n_epwe++;
    end
  end

  // Bus must hold still during a cycle and drop cyc after each ack
  logic           p_cyc = 1'b0;
  logic           p_ack = 1'b0;
  logic           p_we  = 1'b0;
  logic [WAW-1:0] p_addr = '0;
  logic [DW-1:0]  p_wdata = '0;
  always @(negedge clk) begin
    if (wb_cyc && p_cyc && !p_ack) begin
      if (wb_addr != p_addr || wb_we != p_we ||
          (wb_we && wb_wdata != p_wdata))
        viol++;
    end
    if (wb_cyc && p_cyc && p_ack) viol++;
    p_cyc   = wb_cyc;
    p_ack   = wb_ack;
    p_we    = wb_we;
    p_addr  = wb_addr;
    p_wdata = wb_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int epi(input int a);
    return a & ((1 << AW) - 1);
  endfunction

  function automatic int wbi(input int a);
    return a & ((1 << WAW) - 1);
  endfunction

  // Reference: a block copy is just len word moves with wrapping addresses
  task automatic model(input bit dir, input int ea, input int wa,
                       input int len);
    for (int i = 0; i < len; i++) begin
      if (dir) exp_ep[epi(ea + i)] = exp_wb[wbi(wa + i)];
      else     exp_wb[wbi(wa + i)] = exp_ep[epi(ea + i)];
    end
  endtask

  task automatic check_data(input string tag, input bit dir,
                            input int ea, input int wa, input int len);
    for (int i = 0; i < len; i++) begin
      if (dir) chk({tag, "_epdata"}, ep_mem[epi(ea + i)],
                   exp_ep[epi(ea + i)]);
      else     chk({tag, "_wbdata"}, wb_mem[wbi(wa + i)],
                   exp_wb[wbi(wa + i)]);
    end
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  // Called just after a negedge; returns just after a negedge
  task automatic run_cmd(input string tag, input bit dir, input int ea,
                         input int wa, input int len, input int wsi,
                         input int exp_lat);
    int b_wwr = n_wwr;
    int b_wrd = n_wrd;
    int b_we  = n_epwe;
    int b_re  = n_epre;
    int b_v   = viol;
    int lat;
    model(dir, ea, wa, len);
    ws          = wsi;
    cmd_dir     = dir;
    cmd_ep_addr = AW'(ea);
    cmd_wb_addr = WAW'(wa);
    cmd_len     = LW'(len);
    cmd_valid   = 1'b1;
    chk({tag, "_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(tag, lat);
    chk({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_ready_after"}, cmd_ready, 1);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_wb_wr_n"}, n_wwr - b_wwr, dir ? 0 : len);
    chk({tag, "_wb_rd_n"}, n_wrd - b_wrd, dir ? len : 0);
    chk({tag, "_ep_we_n"}, n_epwe - b_we, dir ? len : 0);
    chk({tag, "_ep_re_n"}, n_epre - b_re, dir ? 0 : len);
    chk({tag, "_bus_stable"}, viol - b_v, 0);
    check_data(tag, dir, ea, wa, len);
  endtask

  typedef struct {
    bit dir;
    int ea;
    int wa;
    int len;
    int ws;
    int base;
    int lat;
  } vec_t;

  vec_t vt [5];

  initial begin
    int lat;
    int nd;
    int b;
    int bad;
    vt[0] = '{1'b0, 'h010, 'h0100, 4, 0, 'hA0, 17};
    vt[1] = '{1'b1, 'h1FE, 'h2000, 4, 0, 'h11, 13};
    vt[2] = '{1'b0, 'h020, 'h0200, 0, 0, 0, 1};
    vt[3] = '{1'b0, 'h030, 'h0300, 2, 3, 'h55, 15};
    vt[4] = '{1'b1, 'h0F0, 'hFFFE, 3, 2, 'h77, 16};

    for (int i = 0; i < (1 << AW); i++) begin
      ep_mem[i] = $urandom;
      exp_ep[i] = ep_mem[i];
    end
    for (int i = 0; i < (1 << WAW); i++) begin
      wb_mem[i] = $urandom;
      exp_wb[i] = wb_mem[i];
    end

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_dir     = 1'b0;
    cmd_ep_addr = '0;
    cmd_wb_addr = '0;
    cmd_len     = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_ep_we", ep_tx_we_0, 0);
    chk("rst_ep_re", ep_rx_re_0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_addrs", {wb_addr, ep_tx_addr_0, ep_rx_addr_0}, 0);
    chk("rst_data", {wb_wdata, ep_tx_data_0}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vt[v].len; i++) begin
        if (vt[v].dir) begin
          wb_mem[wbi(vt[v].wa + i)] = vt[v].base + i;
          exp_wb[wbi(vt[v].wa + i)] = vt[v].base + i;
        end else begin
          ep_mem[epi(vt[v].ea + i)] = vt[v].base + i;
          exp_ep[epi(vt[v].ea + i)] = vt[v].base + i;
        end
      end
      run_cmd($sformatf("vec%0d", v), vt[v].dir, vt[v].ea, vt[v].wa,
              vt[v].len, vt[v].ws, vt[v].lat);
    end
    chk("plan1_w0", wb_mem['h0100], 'hA0);
    chk("plan1_w3", wb_mem['h0103], 'hA3);
    chk("plan2_1ff", ep_mem['h1FF], 'h12);
    chk("plan2_wrap", ep_mem['h001], 'h14);

    // Second command held during a busy transfer
    b = n_wwr;
    model(1'b1, 'h040, 'h3000, 3);
    ws          = 0;
    cmd_dir     = 1'b1;
    cmd_ep_addr = AW'('h040);
    cmd_wb_addr = WAW'('h3000);
    cmd_len     = LW'(3);
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_dir     = 1'b0;
    cmd_ep_addr = AW'('h080);
    cmd_wb_addr = WAW'('h4000);
    cmd_len     = LW'(2);
    wait_done("hold_a", lat);
    chk("hold_a_latency", lat, 10);
    chk("hold_a_not_ready", cmd_ready, 0);
    @(negedge clk);
    chk("hold_b_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    model(1'b0, 'h080, 'h4000, 2);
    wait_done("hold_b", lat);
    chk("hold_b_latency", lat, 9);
    @(negedge clk);
    chk("hold_b_wr_n", n_wwr - b, 2);
    check_data("hold_a", 1'b1, 'h040, 'h3000, 3);
    check_data("hold_b", 1'b0, 'h080, 'h4000, 2);

    // Reset while the second of five words is on the bus
    b           = n_wwr;
    ws          = 0;
    cmd_dir     = 1'b0;
    cmd_ep_addr = AW'('h100);
    cmd_wb_addr = WAW'('h5000);
    cmd_len     = LW'(5);
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!(wb_cyc && !wb_ack && n_wwr - b == 1) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_mid_reached", lat < 200, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cyc", wb_cyc, 0);
    chk("rst_mid_strobes", {ep_tx_we_0, ep_rx_re_0}, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    model(1'b0, 'h100, 'h5000, 1);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", nd, 0);
    chk("rst_mid_partial", n_wwr - b, 1);
    run_cmd("after_rst", 1'b0, 'h1F0, 'h6000, 1, 0, 5);

    for (int r = 0; r < 25; r++) begin
      bit d;
      int len;
      int wsr;
      d   = 1'($urandom_range(1, 0));
      len = $urandom_range(12, 0);
      wsr = $urandom_range(3, 0);
      run_cmd($sformatf("rnd%0d", r), d, $urandom_range(511, 0),
              $urandom_range(65535, 0), len, wsr,
              (len == 0) ? 1 : ((d ? 3 : 4) + wsr) * len + 1);
    end

    bad = 0;
    for (int i = 0; i < (1 << AW); i++)
      if (ep_mem[i] !== exp_ep[i]) bad++;
    for (int i = 0; i < (1 << WAW); i++)
      if (wb_mem[i] !== exp_wb[i]) bad++;
    chk("mem_all", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
